// File: rtl/ap_mem_sequencer.sv
// Single-pass sequencer for the AP vector memory: it writes producer rows to rows 0..len-1
// and replays each row to the consumer once that row has been committed.
module ap_mem_sequencer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 32,
  parameter int max_rows      = 2001
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [31:0]                            no_of_rows,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   len_err,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [element_width*no_of_units-1:0]   wr_data,
  output logic                                   rd_valid,
  input  logic                                   rd_ready,
  output logic [element_width*no_of_units-1:0]   rd_data,
  output logic [addr_width-1:0]                  mem_address,
  output logic                                   mem_write_enable,
  output logic [element_width*no_of_units-1:0]   mem_input_data,
  output logic [addr_width-1:0]                  mem_read_address,
  input  logic [element_width*no_of_units-1:0]   mem_output,
  output logic                                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a row is offered only once it is in memory.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [31:0]           MAX_ROWS_32 = 32'(max_rows);
  localparam logic [addr_width-1:0] MAX_ROWS_A  = addr_width'(max_rows);
  localparam logic [addr_width-1:0] ONE         = addr_width'(1);

  state_t                 state_q, state_d;
  logic [addr_width-1:0]  wr_cnt_q, wr_cnt_d;
  logic [addr_width-1:0]  rd_cnt_q, rd_cnt_d;
  logic [addr_width-1:0]  len_q, len_d;
  logic                   len_err_q, len_err_d;
  logic                   done_q, done_d;
  logic                   too_long;
  logic                   rd_hs;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a zero-length start never enters RUN; RUN ends on the last read handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && (no_of_rows != 32'd0)) state_d = RUN;
      RUN:  if (rd_cnt_d == len_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy             = (state_q == RUN);
    dbg_state        = (state_q == RUN);
    wr_ready         = busy && (wr_cnt_q < len_q);
    rd_valid         = busy && (rd_cnt_q < wr_cnt_q);
    mem_write_enable = wr_valid && wr_ready;
    mem_address      = wr_cnt_q;
    mem_input_data   = wr_data;
    mem_read_address = rd_cnt_q;
    rd_data          = mem_output;
    done             = done_q;
    len_err          = len_err_q;
  end

  assign rd_hs    = rd_valid && rd_ready;
  assign too_long = (no_of_rows > MAX_ROWS_32);

  // Counters, pass length and status flags
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    done_d    = 1'b0;
    if ((state_q == IDLE) && start) begin
      len_d     = too_long ? MAX_ROWS_A : addr_width'(no_of_rows);
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      len_err_d = too_long;
      done_d    = (no_of_rows == 32'd0);
    end else begin
      if (mem_write_enable) wr_cnt_d = wr_cnt_q + ONE;
      if (rd_hs)            rd_cnt_d = rd_cnt_q + ONE;
      if (busy && (rd_cnt_d == len_q)) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ap_mem_sequencer.sv
// Directed bench for ap_mem_sequencer: a behavioural memory, a cycle model of the
// sequencer's handshake outputs, and a row scoreboard fed by memory writes.
module tb_ap_mem_sequencer;

  localparam int EW   = 32;
  localparam int NU   = 8;
  localparam int AW   = 32;
  localparam int MAXR = 2001;
  localparam int W    = EW * NU;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start;
  logic [31:0]   no_of_rows;
  logic          busy, done, len_err;
  logic          wr_valid, wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid, rd_ready;
  logic [W-1:0]  rd_data;
  logic [AW-1:0] mem_address, mem_read_address;
  logic          mem_write_enable;
  logic [W-1:0]  mem_input_data, mem_output;
  logic          dbg_state;

  ap_mem_sequencer #(
    .element_width(EW), .no_of_units(NU), .addr_width(AW), .max_rows(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .no_of_rows(no_of_rows),
    .busy(busy), .done(done), .len_err(len_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_input_data(mem_input_data), .mem_read_address(mem_read_address),
    .mem_output(mem_output), .dbg_state(dbg_state)
  );

  // behavioural memory, combinational read
  logic [W-1:0] mem [0:2047];
  always_ff @(posedge clk) if (mem_write_enable) mem[mem_address[10:0]] <= mem_input_data;
  assign mem_output = mem[mem_read_address[10:0]];

  // scoreboard and model state
  logic [W-1:0] exp_q[$];
  int n_checks, n_errors;
  int wr_n, rd_n, m_len, done_cnt, last_wr_addr;
  bit m_busy, m_done, m_len_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_len_err = 0; m_len = 0;
    wr_n = 0; rd_n = 0; exp_q.delete();
  endtask

  // One clock: check outputs at the falling edge, update the model, advance past the rising edge.
  task automatic cycle();
    logic [W-1:0] got;
    bit nb, nd;
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("dbg_state", dbg_state, m_busy);
    chk("done", done, m_done);
    chk("len_err", len_err, m_len_err);
    chk("wr_ready", wr_ready, m_busy && (wr_n < m_len));
    chk("rd_valid", rd_valid, m_busy && (exp_q.size() > 0));
    chk("mem_write_enable", mem_write_enable, wr_valid && m_busy && (wr_n < m_len));
    chk("mem_address", mem_address, wr_n);
    chk("mem_read_address", mem_read_address, rd_n);
    if (done) done_cnt++;
    nb = m_busy;
    nd = 1'b0;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("rd_data", rd_data, got);
      end
      rd_n++;
      if (m_busy && (rd_n == m_len)) begin
        nb = 1'b0;
        nd = 1'b1;
      end
    end
    if (mem_write_enable) begin
      chk("mem_input_data", mem_input_data, wr_data);
      exp_q.push_back(wr_data);
      last_wr_addr = wr_n;
      wr_n++;
    end
    if (!m_busy && start && !reset) begin
      m_len     = (no_of_rows > 32'(MAXR)) ? MAXR : int'(no_of_rows);
      m_len_err = (no_of_rows > 32'(MAXR));
      wr_n = 0;
      rd_n = 0;
      exp_q.delete();
      nb = (m_len > 0);
      nd = (m_len == 0);
    end
    @(posedge clk);
    m_busy = nb;
    m_done = nd;
    #1;
  endtask

  task automatic start_pass(input int n);
    start = 1'b1;
    no_of_rows = 32'(n);
    cycle();
    start = 1'b0;
  endtask

  task automatic run_traffic(input int budget, input int v_pct, input int r_pct,
                             input logic [W-1:0] base);
    for (int i = 0; i < budget && !m_done; i++) begin
      wr_valid = ($urandom_range(99) < v_pct);
      wr_data  = base + W'(wr_n);
      rd_ready = ($urandom_range(99) < r_pct);
      cycle();
    end
    chk("pass_end_done", done, 1'b1);
  endtask

  // a couple of idle cycles with the producer still pushing: no writes, done falls
  task automatic tail();
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    int d0;
    n_checks = 0; n_errors = 0; done_cnt = 0; last_wr_addr = -1;
    reset = 1'b1; start = 1'b0; no_of_rows = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_read_address", mem_read_address, 0);
    reset = 1'b0;
    cycle();

    // four rows back-to-back, consumer always ready
    d0 = done_cnt;
    start_pass(4);
    chk("t1_busy", busy, 1'b1);
    run_traffic(50, 100, 100, W'('hA0));
    chk("t1_writes", wr_n, 4);
    chk("t1_last_addr", last_wr_addr, 3);
    tail();
    chk("t1_done_count", done_cnt - d0, 1);

    // consumer ready before any write; a start during RUN is ignored
    d0 = done_cnt;
    start_pass(3);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (4) cycle();
    start = 1'b1;
    no_of_rows = 32'd7;
    cycle();
    start = 1'b0;
    run_traffic(200, 50, 100, W'('hB00));
    chk("t2_writes", wr_n, 3);
    tail();
    chk("t2_done_count", done_cnt - d0, 1);

    // long pass, producer always valid, consumer slower
    d0 = done_cnt;
    start_pass(2000);
    run_traffic(20000, 100, 50, W'('h10000));
    chk("t3_writes", wr_n, 2000);
    chk("t3_last_addr", last_wr_addr, 1999);
    tail();
    chk("t3_done_count", done_cnt - d0, 1);

    // over-length pass is clamped and flagged
    d0 = done_cnt;
    start_pass(5000);
    chk("t4_len_err", len_err, 1'b1);
    run_traffic(20000, 80, 70, W'('h20000));
    chk("t4_writes", wr_n, MAXR);
    chk("t4_last_addr", last_wr_addr, MAXR - 1);
    tail();
    chk("t4_done_count", done_cnt - d0, 1);
    start_pass(10);
    chk("t4_len_err_clear", len_err, 1'b0);
    run_traffic(200, 70, 70, W'('h30000));
    chk("t4b_writes", wr_n, 10);
    tail();

    // zero-length pass
    d0 = done_cnt;
    wr_valid = 1'b1;
    start_pass(0);
    chk("t5_busy", busy, 1'b0);
    cycle();
    cycle();
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_writes", wr_n, 0);

    // reset in the middle of a pass
    start_pass(6);
    wr_valid = 1'b1;
    rd_ready = 1'b0;
    wr_data = W'('h50000);
    cycle();
    wr_data = W'('h50001);
    cycle();
    chk("t6_partial_writes", wr_n, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_mem_address", mem_address, 0);
    chk("t6_async_mem_read_address", mem_read_address, 0);
    chk("t6_async_wr_ready", wr_ready, 1'b0);
    model_reset();
    d0 = done_cnt;
    cycle();
    reset = 1'b0;
    wr_valid = 1'b0;
    cycle();
    cycle();
    chk("t6_no_done", done_cnt - d0, 0);
    start_pass(6);
    run_traffic(200, 70, 70, W'('h60000));
    chk("t6_writes", wr_n, 6);
    chk("t6_last_addr", last_wr_addr, 5);
    tail();
    chk("t6_done_count", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
